// File: rtl/ei_axi4_slave_mem_if.sv
// AXI4 bus bundle between the VIP interconnect master and the slave memory responder.
interface ei_axi4_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [NB-1:0]         wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory with FIXED/INCR/WRAP bursts, byte strobes and SLVERR on illegal beats.
// Read data 1 cycle after AR, back-to-back beats; R/B held until rready/bready, one burst per direction.
module ei_axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                 aclk,
  input  logic                 areset,
  ei_axi4_slave_mem_if.slave   axi
);
  localparam int NB     = DATA_WIDTH / 8;
  localparam int SZ_MAX = $clog2(NB);
  localparam int WIDX   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * longint'(NB);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (size > 3'(SZ_MAX)) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
  endfunction

  // Reserved bursts and illegal WRAP lengths fall through to INCR addressing.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] total;
    logic [ADDR_WIDTH-1:0] lower;
    logic [ADDR_WIDTH-1:0] nxt;
    bytes = ADDR_WIDTH'(1) << size;
    total = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * bytes;
    lower = addr & ~(total - ADDR_WIDTH'(1));
    if (burst == 2'b00) begin
      nxt = addr;
    end else if ((burst == 2'b10) && wrap_len_ok(len)) begin
      nxt = addr + bytes;
      if (nxt == lower + total) nxt = lower;
    end else begin
      nxt = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    end
    return nxt;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return 64'(addr) < MEM_BYTES;
  endfunction

  function automatic logic [WIDX-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[SZ_MAX +: WIDX];
  endfunction

  // ---------------- write channel ----------------
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [7:0]            w_beat;
  logic                  w_err;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  w_hs;
  logic                  w_last_beat;
  logic                  w_beat_err;

  assign axi.awready = (w_state == W_IDLE) && !areset;
  assign axi.wready  = (w_state == W_DATA) && !areset;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;

  assign w_hs        = axi.wvalid && axi.wready;
  assign w_last_beat = (w_beat == w_len);
  assign w_beat_err  = !in_range(w_addr) || (axi.wlast != w_last_beat);

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state  <= W_IDLE;
      w_addr   <= '0;
      w_len    <= '0;
      w_size   <= '0;
      w_burst  <= '0;
      w_beat   <= '0;
      w_err    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi.awvalid) begin
            w_addr  <= axi.awaddr;
            w_len   <= axi.awlen;
            w_size  <= axi.awsize;
            w_burst <= axi.awburst;
            w_beat  <= '0;
            w_err   <= burst_err(axi.awlen, axi.awsize, axi.awburst);
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_beat <= w_beat + 8'd1;
            if (w_beat_err) w_err <= 1'b1;
            if (w_last_beat) begin
              bvalid_q <= 1'b1;
              bresp_q  <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset && w_hs && in_range(w_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (axi.wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_beat;
  logic                  r_err;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_err;
  logic                  ld_ok;

  assign axi.arready = (r_state == R_IDLE) && !areset;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_q;

  // r_addr always holds the address of the next beat to load.
  always_comb begin
    ld_addr = r_addr;
    ld_err  = r_err;
    if (r_state == R_IDLE) begin
      ld_addr = axi.araddr;
      ld_err  = burst_err(axi.arlen, axi.arsize, axi.arburst);
    end
  end

  assign ld_ok = in_range(ld_addr);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= R_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_beat   <= '0;
      r_err    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi.arvalid) begin
            r_len    <= axi.arlen;
            r_size   <= axi.arsize;
            r_burst  <= axi.arburst;
            r_err    <= ld_err;
            r_beat   <= '0;
            r_addr   <= next_addr(axi.araddr, axi.arlen, axi.arsize, axi.arburst);
            rvalid_q <= 1'b1;
            rlast_q  <= (axi.arlen == 8'd0);
            rresp_q  <= (ld_err || !ld_ok) ? 2'b10 : 2'b00;
            rdata_q  <= ld_ok ? mem[word_idx(ld_addr)] : '0;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              r_state  <= R_IDLE;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_addr  <= next_addr(r_addr, r_len, r_size, r_burst);
              rlast_q <= ((r_beat + 8'd1) == r_len);
              rresp_q <= (ld_err || !ld_ok) ? 2'b10 : 2'b00;
              rdata_q <= ld_ok ? mem[word_idx(ld_addr)] : '0;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Scoreboard bench for ei_axi4_slave_mem: a byte-level memory model predicts B and R traffic.
module tb_ei_axi4_slave_mem;
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  ei_axi4_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  ei_axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .aclk   (aclk),
    .areset (areset),
    .axi    (axi)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [1:0]  b_exp_q[$];
  rexp_t       r_exp_q[$];
  logic [31:0] model [1024];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic wrap_legal(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

  function automatic logic tb_burst_err(input logic [7:0] len, input logic [2:0] size,
                                        input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) || (burst == 2'b10 && !wrap_legal(len));
  endfunction

  // Address of beat i, computed directly from the burst start rather than stepwise.
  function automatic logic [31:0] tb_beat_addr(input logic [31:0] start, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input int i);
    logic [31:0] bytes;
    logic [31:0] total;
    logic [31:0] base;
    bytes = 32'd1 << size;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && wrap_legal(len)) begin
      total = (32'(len) + 32'd1) * bytes;
      base  = start & ~(total - 32'd1);
      return base + ((start - base + 32'(i) * bytes) % total);
    end
    if (i == 0) return start;
    return (start & ~(bytes - 32'd1)) + 32'(i) * bytes;
  endfunction

  task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last);
    rexp_t e;
    e.data = data;
    e.resp = resp;
    e.last = last;
    r_exp_q.push_back(e);
  endtask

  task automatic push_model(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic        ok;
    for (int i = 0; i <= int'(len); i++) begin
      a  = tb_beat_addr(addr, len, size, burst, i);
      ok = (a < 32'h1000);
      push_r(ok ? model[a[11:2]] : 32'h0,
             (tb_burst_err(len, size, burst) || !ok) ? 2'b10 : 2'b00, i == int'(len));
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit bad_last, input int b_delay,
                           input int rst_beat);
    logic        err;
    logic [31:0] a;
    int          t;
    err = tb_burst_err(len, size, burst) || bad_last;
    axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    axi.awvalid = 1'b1;
    t = 0;
    while (!axi.awready && t < 100) begin @(posedge aclk); #1; t++; end
    if (!axi.awready) check("aw_timeout", 0, 1);
    @(posedge aclk); #1;
    axi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = tb_beat_addr(addr, len, size, burst, i);
      axi.wdata  = wd[i];
      axi.wstrb  = ws[i];
      axi.wlast  = (i == int'(len)) && !bad_last;
      axi.wvalid = 1'b1;
      t = 0;
      while (!axi.wready && t < 100) begin @(posedge aclk); #1; t++; end
      if (!axi.wready) check("w_timeout", 0, 1);
      if (i == rst_beat) begin
        areset = 1'b1;
        @(posedge aclk); #1;
        check("mid_rst_ctl", {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rlast}, 0);
        check("mid_rst_dat", {axi.rdata, axi.bresp, axi.rresp}, 0);
        axi.wvalid = 1'b0; axi.wlast = 1'b0; areset = 1'b0;
        #1;
        check("mid_rst_awrdy", axi.awready, 1);
        return;
      end
      @(posedge aclk); #1;
      if (a < 32'h1000) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model[a[11:2]][8*b +: 8] = wd[i][8*b +: 8];
      end else begin
        err = 1'b1;
      end
    end
    axi.wvalid = 1'b0;
    axi.wlast  = 1'b0;
    b_exp_q.push_back(err ? 2'b10 : 2'b00);
    if (b_delay > 0) begin
      repeat (b_delay) begin @(posedge aclk); #1; end
      check("b_hold", {axi.bvalid, axi.awready}, 2'b10);
    end
    axi.bready = 1'b1;
    t = 0;
    while (!axi.bvalid && t < 100) begin @(posedge aclk); #1; t++; end
    if (!axi.bvalid) check("b_timeout", 0, 1);
    check("bresp", axi.bresp, b_exp_q.pop_front());
    @(posedge aclk); #1;
    axi.bready = 1'b0;
    check("b_drop", {axi.bvalid, axi.awready}, 2'b01);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int stall_beat, input int stall_cyc);
    rexp_t       e;
    logic [31:0] hold_d;
    logic        hold_l;
    int          t;
    axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    axi.arvalid = 1'b1;
    t = 0;
    while (!axi.arready && t < 100) begin @(posedge aclk); #1; t++; end
    if (!axi.arready) check("ar_timeout", 0, 1);
    @(posedge aclk); #1;
    axi.arvalid = 1'b0;
    check("r_latency", axi.rvalid, 1);
    axi.rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!axi.rvalid && t < 100) begin @(posedge aclk); #1; t++; end
      if (!axi.rvalid) check("r_timeout", 0, 1);
      if (r_exp_q.size() == 0) begin
        check("r_unexpected", 1, 0);
      end else begin
        e = r_exp_q.pop_front();
        check("rdata", axi.rdata, e.data);
        check("rresp", axi.rresp, e.resp);
        check("rlast", axi.rlast, e.last);
      end
      if (i == stall_beat) begin
        axi.rready = 1'b0;
        hold_d = axi.rdata;
        hold_l = axi.rlast;
        repeat (stall_cyc) begin @(posedge aclk); #1; end
        check("r_stall", {axi.rvalid, axi.rlast, axi.rdata}, {1'b1, hold_l, hold_d});
        axi.rready = 1'b1;
      end
      @(posedge aclk); #1;
    end
    axi.rready = 1'b0;
    check("r_end", axi.rvalid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_ctl", {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rlast}, 0);
    check("rst_dat", {axi.rdata, axi.bresp, axi.rresp}, 0);
    areset = 1'b0;
    #1;
    check("rst_rdy", {axi.awready, axi.arready, axi.wready}, 3'b110);

    // INCR burst write and readback
    for (int k = 0; k < 16; k++) begin wd[k] = 32'hA0 + k; ws[k] = 4'hF; end
    axi_write(32'h10, 8'd3, 3'd2, 2'b01, 1'b0, 0, -1);
    push_model(32'h10, 8'd3, 3'd2, 2'b01);
    axi_read(32'h10, 8'd3, 3'd2, 2'b01, -1, 0);

    // WRAP write, checked both as a WRAP read and by absolute address
    for (int k = 0; k < 4; k++) wd[k] = 32'hB0 + k;
    axi_write(32'h38, 8'd3, 3'd2, 2'b10, 1'b0, 0, -1);
    push_model(32'h38, 8'd3, 3'd2, 2'b10);
    axi_read(32'h38, 8'd3, 3'd2, 2'b10, -1, 0);
    push_r(32'hB2, 2'b00, 1'b0);
    push_r(32'hB3, 2'b00, 1'b0);
    push_r(32'hB0, 2'b00, 1'b0);
    push_r(32'hB1, 2'b00, 1'b1);
    axi_read(32'h30, 8'd3, 3'd2, 2'b01, -1, 0);

    // FIXED: only the last beat survives
    for (int k = 0; k < 4; k++) wd[k] = 32'hC0 + k;
    axi_write(32'h40, 8'd3, 3'd2, 2'b00, 1'b0, 0, -1);
    push_r(32'hC3, 2'b00, 1'b1);
    axi_read(32'h40, 8'd0, 3'd2, 2'b01, -1, 0);

    // byte strobes
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    axi_write(32'h0, 8'd0, 3'd2, 2'b01, 1'b0, 0, -1);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    axi_write(32'h0, 8'd0, 3'd2, 2'b01, 1'b0, 0, -1);
    push_r(32'h11BB33DD, 2'b00, 1'b1);
    axi_read(32'h0, 8'd0, 3'd2, 2'b01, -1, 0);

    // out-of-range write/read; word 0 must not be aliased
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(32'h1000, 8'd0, 3'd2, 2'b01, 1'b0, 0, -1);
    push_r(32'h0, 2'b10, 1'b1);
    axi_read(32'h1000, 8'd0, 3'd2, 2'b01, -1, 0);
    push_r(32'h11BB33DD, 2'b00, 1'b1);
    axi_read(32'h0, 8'd0, 3'd2, 2'b01, -1, 0);

    // oversize beats, bad wlast, reserved burst, illegal WRAP length
    axi_write(32'h80, 8'd0, 3'd3, 2'b01, 1'b0, 0, -1);
    push_model(32'h10, 8'd0, 3'd3, 2'b01);
    axi_read(32'h10, 8'd0, 3'd3, 2'b01, -1, 0);
    for (int k = 0; k < 4; k++) begin wd[k] = 32'hE1 + k; ws[k] = 4'hF; end
    axi_write(32'h90, 8'd1, 3'd2, 2'b01, 1'b1, 0, -1);
    axi_write(32'hA0, 8'd1, 3'd2, 2'b11, 1'b0, 0, -1);
    push_model(32'hA0, 8'd1, 3'd2, 2'b01);
    axi_read(32'hA0, 8'd1, 3'd2, 2'b01, -1, 0);
    axi_write(32'hB0, 8'd2, 3'd2, 2'b10, 1'b0, 0, -1);
    push_model(32'hB0, 8'd2, 3'd2, 2'b01);
    axi_read(32'hB0, 8'd2, 3'd2, 2'b01, -1, 0);

    // backpressure on R and B
    push_model(32'h10, 8'd3, 3'd2, 2'b01);
    axi_read(32'h10, 8'd3, 3'd2, 2'b01, 1, 5);
    wd[0] = 32'h5A5A0001;
    axi_write(32'h100, 8'd0, 3'd2, 2'b01, 1'b0, 4, -1);

    // reset during beat 2 of an 8-beat write over known contents
    for (int k = 0; k < 8; k++) begin wd[k] = 32'hE0 + k; ws[k] = 4'hF; end
    axi_write(32'h200, 8'd7, 3'd2, 2'b01, 1'b0, 0, -1);
    for (int k = 0; k < 8; k++) wd[k] = 32'hD0 + k;
    axi_write(32'h200, 8'd7, 3'd2, 2'b01, 1'b0, 0, 2);
    push_model(32'h200, 8'd7, 3'd2, 2'b01);
    axi_read(32'h200, 8'd7, 3'd2, 2'b01, -1, 0);

    check("r_queue_empty", r_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
